// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
// Used by reset_sequencer and reset_sync_chain (RESET_SEQ_ACK_EN adds the ack handshake).
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Lower bounds for legal parameter values.
    localparam int MIN_NUM_OUT     = 1;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_HOLD_CYCLES = 1;
    localparam int MIN_GAP_CYCLES  = 1;

    // Width of a counter that must hold terminal values HOLD-1 and GAP-1.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchroniser: asynchronous set, shifts in 0, output is the last stage.
module reset_sync_chain
    import reset_seq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_sync_rst
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b0};
        end
    end

    assign o_sync_rst = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset generator: synchronised release, hold, then ordered per-channel release.
// Optional macro RESET_SEQ_ACK_EN gates each release on the previous domain's ready ack.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               i_clk,
    input  logic               i_in_rst,
    input  logic               i_sw_rst,
`ifdef RESET_SEQ_ACK_EN
    input  logic [NUM_OUT-1:0] i_rst_ack,
`endif
    output logic [NUM_OUT-1:0] o_out_rst,
    output logic               o_rst_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(NUM_OUT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

    if (NUM_OUT < MIN_NUM_OUT || SYNC_STAGES < MIN_SYNC_STAGES ||
        HOLD_CYCLES < MIN_HOLD_CYCLES || GAP_CYCLES < MIN_GAP_CYCLES) begin : g_bad_param
        $error("reset_sequencer: illegal parameter value");
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [NUM_OUT-1:0] r_out_rst, w_out_nxt;
    logic               r_done, w_done_nxt;
    logic               w_sync_rst;
    logic               w_prev_ack;
    logic               w_last_ack;

    reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_in_rst),
        .o_sync_rst (w_sync_rst)
    );

`ifdef RESET_SEQ_ACK_EN
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_OUT);

    // Ack of the most recently released domain, i.e. channel r_idx-1.
    always_comb begin
        w_prev_ack = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (r_idx == IDX_W'(i + 1)) w_prev_ack = i_rst_ack[i];
        end
    end
    assign w_last_ack = i_rst_ack[NUM_OUT-1];
`else
    assign w_prev_ack = 1'b1;
    assign w_last_ack = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_in_rst) begin
        if (i_in_rst) begin
            r_state   <= ST_SYNC;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_out_rst <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_out_rst <= w_out_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Channels release bottom-up, so clearing the next one is a left shift of the thermometer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_out_nxt   = r_out_rst;
        w_done_nxt  = r_done;
        case (r_state)
            ST_SYNC: begin
                if (!w_sync_rst) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_out_nxt = r_out_rst << 1;
                    w_cnt_nxt = '0;
                    w_idx_nxt = IDX_ONE;
                    if (NUM_OUT == 1 && w_last_ack) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
`ifdef RESET_SEQ_ACK_EN
                if (r_idx == IDX_END) begin
                    if (w_last_ack) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end else
`endif
                if (r_cnt == GAP_LAST) begin
                    if (w_prev_ack) begin
                        w_out_nxt = r_out_rst << 1;
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX && w_last_ack) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_RUN;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Software reset restarts the hold phase without re-running the synchroniser.
        if (i_sw_rst && r_state != ST_SYNC) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_out_nxt   = '1;
            w_done_nxt  = 1'b0;
        end
    end

    assign o_out_rst  = r_out_rst;
    assign o_rst_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a NUM_OUT=1 / SYNC_STAGES=3 / HOLD_CYCLES=1 instance.
module tb_reset_sequencer;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sw   = 1'b0;
    logic       rst1 = 1'b1;
    logic       sw1  = 1'b0;
    logic [3:0] out0;
    logic       done0;
    logic [0:0] out1;
    logic       done1;
`ifdef RESET_SEQ_ACK_EN
    logic [3:0] ack  = 4'b1111;
    logic [0:0] ack1 = 1'b1;
`endif
    int         n_cmp = 0;
    int         n_err = 0;
    bit         inv_en = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer u_dut0 (
        .i_clk      (clk),
        .i_in_rst   (rst),
        .i_sw_rst   (sw),
`ifdef RESET_SEQ_ACK_EN
        .i_rst_ack  (ack),
`endif
        .o_out_rst  (out0),
        .o_rst_done (done0)
    );

    reset_sequencer #(
        .NUM_OUT     (1),
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (4)
    ) u_dut1 (
        .i_clk      (clk),
        .i_in_rst   (rst1),
        .i_sw_rst   (sw1),
`ifdef RESET_SEQ_ACK_EN
        .i_rst_ack  (ack1),
`endif
        .o_out_rst  (out1),
        .o_rst_done (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Channel i is released at edge base + 4*i (default GAP_CYCLES=4).
    function automatic logic [3:0] exp_out(input int e, input int base);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (e < base + 4 * i);
        return r;
    endfunction

    function automatic logic is_therm(input logic [3:0] x);
        logic [3:0] z;
        z = ~x;
        return (z & (z + 4'd1)) == 4'd0;
    endfunction

    // Edges e_from..e_to; SW_RST is high for edges sw_from..sw_to.
    task automatic run(input int e_from, input int e_to, input int base,
                       input int sw_from, input int sw_to);
        for (int e = e_from; e <= e_to; e++) begin
            @(negedge clk);
            sw = (e >= sw_from && e <= sw_to);
            @(posedge clk);
            #1;
            chk($sformatf("out@%0d", e), out0, exp_out(e, base));
            chk($sformatf("done@%0d", e), done0, exp_out(e, base) == 4'd0);
        end
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            chk("therm0", is_therm(out0), 1'b1);
            chk("done0_iff", done0, out0 == 4'd0);
            chk("done1_iff", done1, out1 == 1'b0);
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_out0", out0, 4'b1111);
        chk("rst_done0", done0, 1'b0);
        chk("rst_out1", out1, 1'b1);
        chk("rst_done1", done1, 1'b0);
        inv_en = 1'b1;

        // Power-on release: next edge is edge 0.
        #2 rst = 1'b0;
        run(0, 34, 18, -1, -1);

        // Restart, then reassert IN_RST mid-gap after edge 24.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        run(0, 24, 18, -1, -1);
        #1 rst = 1'b1;
        #1;
        chk("async_out", out0, 4'b1111);
        chk("async_done", done0, 1'b0);
        #1 rst = 1'b0;
        run(0, 39, 18, -1, -1);

        // One-cycle SW_RST sampled at edge 40, then SW_RST held for edges 75..84.
        run(40, 74, 56, 40, 40);
        run(75, 115, 100, 75, 84);

        // Small instance: SYNC_STAGES=3, HOLD_CYCLES=1 releases at edge 4.
        #1 rst1 = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("out1@%0d", e), out1, e < 4);
            chk($sformatf("done1@%0d", e), done1, e >= 4);
        end

`ifdef RESET_SEQ_ACK_EN
        // RST_ACK[0] withheld until edge 40 stalls channel 1.
        #1 rst = 1'b1;
        #1 ack = 4'b1110;
        #1 rst = 1'b0;
        for (int e = 0; e <= 52; e++) begin
            @(negedge clk);
            if (e == 40) ack = 4'b1111;
            @(posedge clk);
            #1;
            chk($sformatf("ack_out@%0d", e), out0, {e < 48, e < 44, e < 40, e < 18});
            chk($sformatf("ack_done@%0d", e), done0, e >= 48);
        end
`endif

        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
